// File: rtl/mem_pkg.sv
// Shared definitions for the memory access stage and the multicycle controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [6:0]  LD        = 7'b0000011;
  localparam logic [6:0]  SD        = 7'b0100011;
  localparam logic [6:0]  BEQ       = 7'b1100011;
  localparam logic [6:0]  ALUOP     = 7'b0110011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the memory access stage and the unified memory.
interface mem_access_unit_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [XLEN-1:0]   m_wdata;
  logic              m_ack;
  logic [XLEN-1:0]   m_rdata;

  modport master (output m_req, m_we, m_addr, m_wdata, input m_ack, m_rdata);
  modport slave  (input m_req, m_we, m_addr, m_wdata, output m_ack, m_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// Converts controller memory strobes into a req/ack transaction; owns IR and MDR.
// busy stalls the controller from the strobe cycle until the access completes.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ior_d,
  input  logic              ir_write,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   store_data,
  output logic              busy,
  output logic              err,
  output logic [31:0]       instr,
  output logic [6:0]        op,
  output logic [XLEN-1:0]   mdr,
  mem_access_unit_if.master mem
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              irw_q, irw_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   mdr_q, mdr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              strobe;
  logic              illegal;
  logic              timed_out;
  logic [ADDR_W-1:0] addr_sel;
  logic              unused_addr_hi;

  assign strobe   = mem_read | mem_write;
  assign addr_sel = ior_d ? alu_out[ADDR_W-1:0] : pc[ADDR_W-1:0];
  assign unused_addr_hi = ^{pc[XLEN-1:ADDR_W], alu_out[XLEN-1:ADDR_W]};

  // Fetches need word alignment, data accesses need doubleword alignment.
  assign illegal = (mem_read & mem_write) | (ir_write & mem_write) |
                   (~ior_d & (addr_sel[1:0] != 2'b00)) |
                   ( ior_d & (addr_sel[2:0] != 3'b000));

  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    irw_d   = irw_q;
    instr_d = instr_q;
    mdr_d   = mdr_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          addr_d  = addr_sel;
          wdata_d = store_data;
          we_d    = mem_write;
          irw_d   = ir_write;
          cnt_d   = '0;
          if (illegal) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem.m_ack) begin
          if (!we_q) begin
            if (irw_q) instr_d = addr_q[2] ? mem.m_rdata[63:32] : mem.m_rdata[31:0];
            else       mdr_d   = mem.m_rdata;
          end
          state_d = DONE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      instr_q <= NOP_INSTR;
      mdr_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      irw_q   <= irw_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q == REQ) | ((state_q == IDLE) & strobe);
  assign err         = err_q;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign mdr         = mdr_q;
  assign mem.m_req   = (state_q == REQ);
  assign mem.m_we    = we_q;
  assign mem.m_addr  = addr_q;
  assign mem.m_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench with an expected-result queue and a small memory responder.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, ior_d, ir_write;
  logic [63:0] pc, alu_out, store_data;
  logic        busy, err;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [63:0] mdr;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) mem ();

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .ior_d(ior_d), .ir_write(ir_write), .pc(pc), .alu_out(alu_out),
    .store_data(store_data), .busy(busy), .err(err), .instr(instr),
    .op(op), .mdr(mdr), .mem(mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, iord, irw;
    logic [63:0] pc, alu, sd, rdata;
    int          ack_after;
    logic        e_err;
    int          e_req, e_busy;
    logic        e_we;
    logic [31:0] e_addr;
    logic [63:0] e_wdata;
    logic [31:0] e_instr;
    logic [63:0] e_mdr;
  } vec_t;

  vec_t vt[10];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   busy_cyc, req_cyc;
    bit   done;
    busy_cyc = 0; req_cyc = 0; done = 1'b0;
    exp_q.push_back(v);
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; ior_d = v.iord; ir_write = v.irw;
    pc = v.pc; alu_out = v.alu; store_data = v.sd; mem.m_rdata = v.rdata;
    #1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (busy) busy_cyc++;
      if (mem.m_req) begin
        req_cyc++;
        chk("m_addr", 64'(mem.m_addr), 64'(v.e_addr));
        chk("m_we", 64'(mem.m_we), 64'(v.e_we));
        if (v.e_we) chk("m_wdata", mem.m_wdata, v.e_wdata);
        mem.m_ack = (v.ack_after != 0) && (req_cyc == v.ack_after);
      end else begin
        mem.m_ack = 1'b0;
      end
      @(posedge clk); #1;
      if (!busy) done = 1'b1;
    end
    chk("done_reached", 64'(done), 64'd1);
    e = exp_q.pop_front();
    chk("err_in_done", 64'(err), 64'(e.e_err));
    chk("req_cycles", 64'(req_cyc), 64'(e.e_req));
    chk("busy_cycles", 64'(busy_cyc), 64'(e.e_busy));
    chk("instr", 64'(instr), 64'(e.e_instr));
    chk("op", 64'(op), 64'(e.e_instr[6:0]));
    chk("mdr", mdr, e.e_mdr);
    // Late acknowledge with the strobe still held during the completion cycle.
    mem.m_ack = 1'b1;
    mem.m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
    @(posedge clk); #1;
    chk("err_single_pulse", 64'(err), 64'd0);
    chk("idle_no_req", 64'(mem.m_req), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("late_ack_mdr", mdr, e.e_mdr);
    chk("late_ack_instr", 64'(instr), 64'(e.e_instr));
    mem.m_ack = 1'b0;
  endtask

  initial begin
    //            rd    wr    iord  irw   pc        alu       sd          rdata                   ack err  req busy we    addr      wdata       instr     mdr
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h10, 64'h0,  64'h0,    64'hAAAA_0000_0000_0003, 2, 1'b0, 2, 3, 1'b0, 32'h10, 64'h0,    32'h3,  64'h0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  64'h28, 64'h0,    64'h0000_0000_DEAD_BEEF, 1, 1'b0, 1, 2, 1'b0, 32'h28, 64'h0,    32'h3,  64'hDEAD_BEEF};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  64'h30, 64'h1234, 64'h0,                   3, 1'b0, 3, 4, 1'b1, 32'h30, 64'h1234, 32'h3,  64'hDEAD_BEEF};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  64'h2C, 64'h0,    64'h5555,                1, 1'b1, 0, 1, 1'b0, 32'h0,  64'h0,    32'h3,  64'hDEAD_BEEF};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  64'h40, 64'h99,   64'h5555,                1, 1'b1, 0, 1, 1'b0, 32'h0,  64'h0,    32'h3,  64'hDEAD_BEEF};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h14, 64'h0,  64'h0,    64'h0000_0063_1234_5678, 1, 1'b0, 1, 2, 1'b0, 32'h14, 64'h0,    32'h63, 64'hDEAD_BEEF};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h16, 64'h0,  64'h0,    64'h1111,                1, 1'b1, 0, 1, 1'b0, 32'h0,  64'h0,    32'h63, 64'hDEAD_BEEF};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h0,  64'h48, 64'h77,   64'h0,                   1, 1'b1, 0, 1, 1'b0, 32'h0,  64'h0,    32'h63, 64'hDEAD_BEEF};
    vt[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  64'h50, 64'h0,    64'h2222,                0, 1'b1, 4, 5, 1'b0, 32'h50, 64'h0,    32'h63, 64'hDEAD_BEEF};
    vt[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h18, 64'h0,  64'h0,    64'hFFFF_FFFF_0000_0033, 2, 1'b0, 2, 3, 1'b0, 32'h18, 64'h0,    32'h33, 64'hDEAD_BEEF};

    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; ior_d = 1'b0; ir_write = 1'b0;
    pc = '0; alu_out = '0; store_data = '0;
    mem.m_ack = 1'b0; mem.m_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req", 64'(mem.m_req), 64'd0);
    chk("rst_m_we", 64'(mem.m_we), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_m_addr", 64'(mem.m_addr), 64'd0);
    chk("rst_m_wdata", mem.m_wdata, 64'd0);
    chk("rst_mdr", mdr, 64'd0);
    chk("rst_instr", 64'(instr), 64'(NOP_INSTR));
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Acknowledge while idle must be ignored.
    mem.m_ack = 1'b1; mem.m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    mem.m_ack = 1'b0;
    chk("idle_ack_mdr", mdr, 64'd0);
    chk("idle_ack_instr", 64'(instr), 64'(NOP_INSTR));
    chk("idle_ack_err", 64'(err), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);
    chk("op_is_aluop", 64'(op), 64'(ALUOP));

    // Reset asserted while a load is waiting in REQ.
    @(negedge clk);
    mem_read = 1'b1; ior_d = 1'b1; ir_write = 1'b0; alu_out = 64'h58;
    @(posedge clk); #1;
    chk("pre_rst_req", 64'(mem.m_req), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_m_req", 64'(mem.m_req), 64'd0);
    chk("midrst_instr", 64'(instr), 64'(NOP_INSTR));
    chk("midrst_mdr", mdr, 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_busy_strobe", 64'(busy), 64'd1);
    mem_read = 1'b0;
    #1;
    chk("midrst_busy_nostrobe", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req", 64'(mem.m_req), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
